gpio_stream_reader: RTL

//  Parametrised GPIO readback bridge: CPU drains NUM_CH AXI-stream sources of arbitrary DATA_W
//  32 bits per GPIO read strobe (w_clk level handshake), plus NUM_STAT static status words.

---
 rtl/gpio_stream_reader.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/gpio_stream_reader.sv
// GPIO readback bridge: the CPU drains NUM_CH AXI-stream channels 32 bits per w_clk strobe,
// and reads back per-channel word index / underflow status and NUM_STAT static status words.
module gpio_stream_reader #(
    parameter int                NUM_CH    = 4,
    parameter int                DATA_W    = 128,
    parameter int                NUM_STAT  = 4,
    parameter int                ADDR_W    = 8,
    parameter int                W_CLK_BIT = 31,
    parameter logic [ADDR_W-1:0] CH_BASE   = 8'h10,
    parameter logic [ADDR_W-1:0] IDX_BASE  = 8'h18,
    parameter logic [ADDR_W-1:0] STAT_BASE = 8'h20,
    parameter logic [ADDR_W-1:0] CLR_ADDR  = 8'h0F,
    parameter int                UF_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              gpio_in,
    output logic [31:0]              gpio_out,
    output logic                     valid,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    input  logic [NUM_CH-1:0]        s_valid,
    output logic [NUM_CH-1:0]        s_ready,
    input  logic [NUM_STAT*32-1:0]   stat_in
);

    localparam int WORDS      = (DATA_W + 31) / 32;
    localparam int PAD_W      = WORDS * 32;
    localparam int CH_SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STAT_SEL_W = (NUM_STAT > 1) ? $clog2(NUM_STAT) : 1;

    function automatic bit ranges_overlap(input int a_lo, input int a_n, input int b_lo, input int b_n);
        return (a_lo < b_lo + b_n) && (b_lo < a_lo + a_n);
    endfunction

    localparam bit MAP_OVERLAP =
        ranges_overlap(int'(CH_BASE), NUM_CH, int'(IDX_BASE), NUM_CH) ||
        ranges_overlap(int'(CH_BASE), NUM_CH, int'(STAT_BASE), NUM_STAT) ||
        ranges_overlap(int'(CH_BASE), NUM_CH, int'(CLR_ADDR), 1) ||
        ranges_overlap(int'(IDX_BASE), NUM_CH, int'(STAT_BASE), NUM_STAT) ||
        ranges_overlap(int'(IDX_BASE), NUM_CH, int'(CLR_ADDR), 1) ||
        ranges_overlap(int'(STAT_BASE), NUM_STAT, int'(CLR_ADDR), 1);

    generate
        if (MAP_OVERLAP) begin : g_map_overlap
            $error("gpio_stream_reader: address ranges overlap");
        end
        if (W_CLK_BIT < ADDR_W || W_CLK_BIT > 31) begin : g_bad_wclk
            $error("gpio_stream_reader: W_CLK_BIT must lie above the address field");
        end
        if (WORDS < 1 || WORDS > 255) begin : g_bad_words
            $error("gpio_stream_reader: DATA_W must give 1..255 words per beat");
        end
        if (UF_W < 1 || UF_W > 16) begin : g_bad_uf
            $error("gpio_stream_reader: UF_W must be 1..16");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state_r;
    logic [31:0]         rd_reg_r;
    logic                rd_valid_r;
    logic [NUM_CH-1:0]   s_ready_r;
    logic [7:0]          word_idx_r [NUM_CH];
    logic [UF_W-1:0]     uf_cnt_r   [NUM_CH];

    logic [ADDR_W-1:0]   addr_s;
    logic                w_clk_s;
    logic                ch_hit_s;
    logic                idx_hit_s;
    logic                stat_hit_s;
    logic                clr_hit_s;
    logic [CH_SEL_W-1:0] ch_sel_s;
    logic [CH_SEL_W-1:0] idx_sel_s;
    logic [STAT_SEL_W-1:0] stat_sel_s;
    logic [DATA_W-1:0]   sel_beat_s;
    logic [7:0]          sel_idx_s;
    logic                sel_valid_s;
    logic [PAD_W-1:0]    padded_s;
    logic [31:0]         sel_word_s;
    logic [31:0]         idx_word_s;
    logic [31:0]         stat_word_s;
    logic                unused_gpio_s;

    assign addr_s        = gpio_in[ADDR_W-1:0];
    assign w_clk_s       = gpio_in[W_CLK_BIT];
    assign clr_hit_s     = (addr_s == CLR_ADDR);
    assign unused_gpio_s = ^gpio_in;
    assign s_ready       = s_ready_r;

    // Address decode into channel / index-status / status-word windows
    always_comb begin
        ch_hit_s   = 1'b0;
        ch_sel_s   = '0;
        idx_hit_s  = 1'b0;
        idx_sel_s  = '0;
        stat_hit_s = 1'b0;
        stat_sel_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr_s == ADDR_W'(int'(CH_BASE) + c)) begin
                ch_hit_s = 1'b1;
                ch_sel_s = CH_SEL_W'(c);
            end
            if (addr_s == ADDR_W'(int'(IDX_BASE) + c)) begin
                idx_hit_s = 1'b1;
                idx_sel_s = CH_SEL_W'(c);
            end
        end
        for (int k = 0; k < NUM_STAT; k++) begin
            if (addr_s == ADDR_W'(int'(STAT_BASE) + k)) begin
                stat_hit_s = 1'b1;
                stat_sel_s = STAT_SEL_W'(k);
            end
        end
    end

    // Per-address data selection: addressed beat word, index/underflow status, status word
    always_comb begin
        sel_beat_s  = '0;
        sel_idx_s   = 8'h00;
        sel_valid_s = 1'b0;
        idx_word_s  = 32'h0;
        stat_word_s = 32'h0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel_s == CH_SEL_W'(c)) begin
                sel_beat_s  = s_data[c*DATA_W +: DATA_W];
                sel_idx_s   = word_idx_r[c];
                sel_valid_s = s_valid[c];
            end
            if (idx_sel_s == CH_SEL_W'(c)) begin
                idx_word_s = {16'(uf_cnt_r[c]), 8'h00, word_idx_r[c]};
            end
        end
        for (int k = 0; k < NUM_STAT; k++) begin
            if (stat_sel_s == STAT_SEL_W'(k)) begin
                stat_word_s = stat_in[k*32 +: 32];
            end
        end
    end

    // Zero-extend the beat so words beyond DATA_W read as 0
    assign padded_s   = PAD_W'(sel_beat_s);
    assign sel_word_s = padded_s[{sel_idx_s, 5'd0} +: 32];

    // Readback mux and valid flag, combinational on the current address
    always_comb begin
        if (ch_hit_s) begin
            gpio_out = rd_reg_r;
        end else if (idx_hit_s) begin
            gpio_out = idx_word_s;
        end else if (stat_hit_s) begin
            gpio_out = stat_word_s;
        end else begin
            gpio_out = 32'h0;
        end
        if (ch_hit_s || clr_hit_s) begin
            valid = rd_valid_r;
        end else begin
            valid = 1'b1;
        end
    end

    // Strobe FSM: one action per w_clk rising level, then wait for w_clk to drop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            rd_reg_r   <= 32'h0;
            rd_valid_r <= 1'b0;
            s_ready_r  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                word_idx_r[c] <= 8'h00;
                uf_cnt_r[c]   <= '0;
            end
        end else begin
            s_ready_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (w_clk_s) begin
                        state_r <= ST_HOLD;
                        if (ch_hit_s) begin
                            if (sel_valid_s) begin
                                rd_reg_r   <= sel_word_s;
                                rd_valid_r <= 1'b1;
                                if (sel_idx_s == 8'(WORDS - 1)) begin
                                    word_idx_r[ch_sel_s] <= 8'h00;
                                    s_ready_r[ch_sel_s]  <= 1'b1;
                                end else begin
                                    word_idx_r[ch_sel_s] <= sel_idx_s + 8'd1;
                                end
                            end else begin
                                rd_valid_r <= 1'b0;
                                if (uf_cnt_r[ch_sel_s] != {UF_W{1'b1}}) begin
                                    uf_cnt_r[ch_sel_s] <= uf_cnt_r[ch_sel_s] + UF_W'(1);
                                end else begin
                                    uf_cnt_r[ch_sel_s] <= uf_cnt_r[ch_sel_s];
                                end
                            end
                        end else if (clr_hit_s) begin
                            rd_valid_r <= 1'b1;
                            for (int c = 0; c < NUM_CH; c++) begin
                                word_idx_r[c] <= 8'h00;
                                uf_cnt_r[c]   <= '0;
                            end
                        end else begin
                            rd_valid_r <= rd_valid_r;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!w_clk_s) begin
                        rd_valid_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    rd_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
